rr_mux_21_arb: RTL
==================

# rr_mux_21_arb

Two-input round-robin arbiter with a registered 2:1 data mux on its output. It sits directly upstream of downstream consumers that take a single stream. It merges two valid/ready producer channels into one output stream and reports which channel each output word came from. It replaces a free-running 2:1 mux select with a fair, handshake-driven select.

## Interface
- WIDTH, 8, data width of each channel and of the output

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in0_data  input  WIDTH  channel 0 data
- in0_valid  input  1  channel 0 has a word
- in0_ready  output  1  channel 0 word accepted this cycle (when in0_valid high)
- in1_data  input  WIDTH  channel 1 data
- in1_valid  input  1  channel 1 has a word
- in1_ready  output  1  channel 1 word accepted this cycle (when in1_valid high)
- out_data  output  WIDTH  registered selected word
- out_sel  output  1  source channel of out_data (0 or 1)
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- load = ~out_valid | out_ready. A word can be accepted only when load=1.
- Grant is combinational from in0_valid, in1_valid, and the `last` register:
  - only one channel valid → grant that channel
  - both valid → grant ~last
  - none valid → no grant
- inX_ready = load & (grant == X) & inX_valid. At most one ready is high per cycle, and ready never rises without valid.
- On a transfer (inX_valid & inX_ready):
  - out_data <= inX_data, out_sel <= X, out_valid <= 1, last <= X.
- load=1 with no grant: out_valid <= 0, and out_data/out_sel hold their previous values.
- FULL with out_ready=0: outputs hold and both readys are 0 (backpressure).
- FULL with out_ready=1 and a grant: the old word leaves and the new word loads in the same cycle. This gives full throughput, one word per cycle.
- Fairness: under continuous dual valid, the grant alternates 0,1,0,1…, and no channel waits more than one transfer.
- Producers must hold data stable while valid and unaccepted. The block does not check this.

## Timing
- Reset (rst=1 at a clk edge), values after that edge:
  - out_valid=0, out_data=0, out_sel=0, last=1, so channel 0 wins the first contention.
  - While rst is high, in0_ready=in1_ready=0.
- Reset mid-operation discards any held word in the same cycle. There is no flush handshake.
- Latency: an input transfer in cycle N gives out_valid=1 with that data in cycle N+1.
- Throughput: 1 word/cycle when out_ready is held high.
- inX_ready depends combinationally on out_ready, out_valid, both valids, and last. out_* are purely registered.
- `last` updates only on a transfer. Idle cycles do not change priority.

## Structure
- Shared include file rr_mux_defs.vh holds:
  - `CH0`/`CH1` channel-ID constants
  - the reset value of `last` (`RR_LAST_RST`=1)
  - the default WIDTH
- One natural sub-module: rr_grant_2, a purely combinational grant unit. Inputs: two valids and last. Outputs: grant and any_grant.
- Data selection and the output register stay in the top module.
- Expected size is about 150–200 lines of RTL including the sub-module.

## Test plan
- Reset then single channel:
  - Stimulus: rst high for 2 cycles, then in0_valid=1, in0_data=8'hA5, out_ready=1.
  - Response: in0_ready=1 in cycle 0, and one cycle later out_valid=1, out_data=A5, out_sel=0.
  - Also check: all outputs are 0 during reset.
- Contention alternation:
  - Stimulus: both valid for 4 cycles, in0_data=8'h10, in1_data=8'h20, out_ready=1.
  - Response: out_sel sequence 0,1,0,1 with data 10,20,10,20.
- Backpressure:
  - Stimulus: FULL with out_data=8'h33, out_ready=0 for 3 cycles, in1_valid=1.
  - Response: out_data holds 33 and in1_ready=0 for all 3 cycles. When out_ready=1, in1 is accepted and the next out_data is in1_data.
- Simultaneous drain and load:
  - Stimulus: FULL, out_ready=1, in1_valid=1 with data 8'h7E.
  - Response: out_valid stays 1 with no bubble, out_data=7E, out_sel=1.
- Drain to empty:
  - Stimulus: FULL, out_ready=1, no valids.
  - Response: next cycle out_valid=0, out_data unchanged. With a later single in1 request, in1 is granted regardless of last.
- Reset mid-stream:
  - Stimulus: assert rst while FULL and both valid.
  - Response: next cycle out_valid=0, out_sel=0, out_data=0. After release, the first contention grants channel 0.

Source files
------------

// File: rtl/rr_mux_21_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_21_arb_pkg
// Shared definitions for the two-input round-robin arbiter / output mux.
//   DEF_WIDTH    : default data width of each channel and of the output
//   CH0 / CH1    : channel identifiers, also the encoding of out_sel / grant
//   RR_LAST_RST  : reset value of the round-robin 'last' register. It is CH1,
//                  so channel 0 wins the first contention after reset.
// ---------------------------------------------------------------------------
package rr_mux_21_arb_pkg;

  localparam int   DEF_WIDTH   = 8;

  localparam logic CH0         = 1'b0;
  localparam logic CH1         = 1'b1;

  localparam logic RR_LAST_RST = CH1;

endpackage : rr_mux_21_arb_pkg

// File: rtl/rr_mux_21_arb_grant.sv
// ---------------------------------------------------------------------------
// rr_grant_2
// Purely combinational two-way round-robin grant unit.
//   valid0, valid1 : request lines of channel 0 / channel 1
//   last           : channel that won the most recent transfer
//   grant          : winning channel (CH0 / CH1); only meaningful when
//                    any_grant is high
//   any_grant      : at least one channel is requesting
// A lone requester always wins. When both request, the channel that did not
// win last time is granted.
// ---------------------------------------------------------------------------
module rr_grant_2
  import rr_mux_21_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant,
  output logic any_grant
);

  always_comb begin
    // NOTE: assigning a default first means every path drives 'grant', so no
    // latch is inferred even if a case arm is later removed.
    grant = CH0;
    unique case ({valid1, valid0})
      2'b01:   grant = CH0;
      2'b10:   grant = CH1;
      2'b11:   grant = ~last;
      default: grant = CH0;
    endcase
    any_grant = valid0 | valid1;
  end

endmodule : rr_grant_2

// File: rtl/rr_mux_21_arb.sv
// ---------------------------------------------------------------------------
// rr_mux_21_arb
// Two-input round-robin arbiter feeding a registered 2:1 data mux. It merges
// two valid/ready producer channels into one output stream and tags each
// output word with its source channel.
//   clk                   : single clock, rising edge
//   rst                   : synchronous, active-high reset
//   in0_data/valid/ready  : producer channel 0
//   in1_data/valid/ready  : producer channel 1
//   out_data              : registered selected word
//   out_sel               : source channel of out_data
//   out_valid             : out_data / out_sel hold a word
//   out_ready             : consumer accepts the word this cycle
// The output register accepts a new word whenever it is empty or being drained
// in the same cycle, so a held-high out_ready gives one word per cycle.
// ---------------------------------------------------------------------------
module rr_mux_21_arb
  import rr_mux_21_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic last;
  logic grant;
  logic any_grant;
  logic load;
  logic xfer;

  rr_grant_2 u_grant (
    .valid0    (in0_valid),
    .valid1    (in1_valid),
    .last      (last),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // The output register can take a word when empty or when its current word
  // leaves this cycle.
  assign load = ~out_valid | out_ready;

  // Readys are held low while reset is asserted, so no producer believes its
  // word was taken in a cycle whose state is about to be discarded.
  assign xfer = load & any_grant & ~rst;

  assign in0_ready = xfer & (grant == CH0) & in0_valid;
  assign in1_ready = xfer & (grant == CH1) & in1_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= CH0;
      out_valid <= 1'b0;
      last      <= RR_LAST_RST;
    end else if (xfer) begin
      out_data  <= (grant == CH1) ? in1_data : in0_data;
      out_sel   <= grant;
      out_valid <= 1'b1;
      last      <= grant;
    end else if (load) begin
      // Word drained (or already empty) with nothing to replace it; data and
      // sel keep their previous values, priority is untouched.
      out_valid <= 1'b0;
    end
  end

endmodule : rr_mux_21_arb
